paillier_key_reader: RTL
========================

// Module: paillier_key_reader
// PURPOSE
//  Drains the four key RAMs of key_generation_top (u, n, g, lambda) once keygen asserts done.
//  Drives the shared out_rd_addr read port and packs the four words into one key record per address.
//  Streams records to encrypt/decrypt engines over a valid/ready interface.
//  Sustains one record per cycle while the consumer holds key_ready high.
// PARAMETERS
//  DATA_WIDTH      1024  width of each key word (u, n, g, lambda)
//  RAM_ADDR_WIDTH  5     key RAM address width; max record count is 2**RAM_ADDR_WIDTH
//  FILE_SIZE       10    record count used when num_keys_i == 0 (default batch size)
// PORTS
//  clock        in   1                 single clock, all logic on posedge
//  reset        in   1                 asynchronous assert, active-low; synchronous deassert external
//  start        in   1                 one-cycle pulse; begin a drain; ignored while busy
//  num_keys_i   in   RAM_ADDR_WIDTH+1  records to drain, sampled on start; 0 selects FILE_SIZE
//  busy         out  1                 high from the cycle after start until done
//  done         out  1                 one-cycle pulse after the last record handshake
//  out_rd_addr  out  RAM_ADDR_WIDTH    shared read address to all four key RAMs
//  u_dout       in   DATA_WIDTH        RAM data, valid 1 cycle after address (registered read)
//  n_dout       in   DATA_WIDTH        same timing as u_dout
//  g_dout       in   DATA_WIDTH        same timing as u_dout
//  lambda_dout  in   DATA_WIDTH        same timing as u_dout
//  key_valid    out  1                 record available
//  key_ready    in   1                 consumer accepts record when valid & ready on posedge
//  key_u        out  DATA_WIDTH        record field u
//  key_n        out  DATA_WIDTH        record field n
//  key_g        out  DATA_WIDTH        record field g
//  key_lambda   out  DATA_WIDTH        record field lambda
//  key_index    out  RAM_ADDR_WIDTH    RAM address this record came from
//  key_last     out  1                 high with the final record of the drain
// BEHAVIOUR
//  Reset (reset==0): all outputs 0, FSM to IDLE, buffer empty, counters 0, immediately (async).
//  FSM states:
//   - IDLE: on start, latch count N = (num_keys_i==0 ? FILE_SIZE : min(num_keys_i, 2**RAM_ADDR_WIDTH)).
//   - IDLE -> RUN on start; issue pointer and accept counter cleared.
//   - RUN: issue address k (0..N-1) when occupancy + in_flight < 2.
//   - RUN: out_rd_addr holds the last issued address; never advances past N-1.
//   - RUN: data returns the next cycle and is written into a 2-entry record FIFO with key_index = k.
//   - RUN -> FINISH when accepted == N.
//   - FINISH: done=1 for exactly one cycle, busy=0; -> IDLE.
//  Latency: start@t0 -> first issue t0+1 -> data t0+2 -> key_valid t0+3 (registered FIFO head).
//  Throughput: with key_ready held high, one record per cycle; no bubbles between records.
//  Handshake rules:
//   - key_valid, once high, stays high and payload stays stable until accepted.
//   - key_ready may toggle freely; valid never depends combinationally on ready.
//   - key_last = (key_index == N-1) on the presented record.
//  Boundaries:
//   - FIFO full + returning read cannot happen (credit rule); assertion in bench.
//   - N == 2**RAM_ADDR_WIDTH: address counter reaches all-ones; no wrap; issue stops by count compare.
//   - N == 1: a single record with key_last=1; done follows its handshake.
//   - start while busy: ignored; no effect on count or pointers.
//   - start in the same cycle as done: ignored; restart is accepted from IDLE only.
//   - out_rd_addr returns to 0 in IDLE.
//  Widths: counters are RAM_ADDR_WIDTH+1 bits so N == 2**RAM_ADDR_WIDTH is representable.
// STRUCTURE
//  paillier_pkg:
//   - key_rec_t struct {u, n, g, lambda, index, last}.
//   - rdr_state_e enum {IDLE, RUN, FINISH}.
//   - KEY_FIFO_DEPTH = 2.
//  Sub-module key_rec_fifo: 2-entry registered FIFO of key_rec_t.
//   - Ports: wr_en, rd_en, full, empty, count.
//   - Same clock and reset, reset active-low async.
//  Top holds the FSM, issue/accept counters and the credit logic.
// TESTING
//  1 Load RAMs with u[i]=i+1, others distinct; num_keys_i=0, ready=1 -> 10 records, idx 0..9, last on 9, one per cycle, done once.
//  2 num_keys_i=4, ready toggles 1,0,0,1,... -> 4 records in order, payload stable while stalled, no loss or duplicates.
//  3 num_keys_i=40 (RAM_ADDR_WIDTH=5) -> clamped to 32 records, last index 31, out_rd_addr never wraps.
//  4 num_keys_i=1 -> single record idx 0 with key_last=1; done 1 cycle after handshake; start during busy ignored.
//  5 reset low mid-drain after 3 records -> all outputs 0 at once; then new start with num_keys_i=2 -> records 0,1 only.
//  6 ready=0 for 20 cycles after start -> out_rd_addr stops after 2 issues, FIFO holds 0,1; release -> rest streamed correctly.

Source files
------------

// File: rtl/paillier_pkg.sv
// Shared types for the Paillier key reader: key record layout, reader FSM states
// and record FIFO sizing.
package paillier_pkg;

    localparam int KEY_DATA_WIDTH = 1024;
    localparam int KEY_ADDR_WIDTH = 5;
    localparam int KEY_FIFO_DEPTH = 2;
    localparam int KEY_FIFO_CNT_W = $clog2(KEY_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [KEY_DATA_WIDTH-1:0] u;
        logic [KEY_DATA_WIDTH-1:0] n;
        logic [KEY_DATA_WIDTH-1:0] g;
        logic [KEY_DATA_WIDTH-1:0] lambda;
        logic [KEY_ADDR_WIDTH-1:0] index;
        logic                      last;
    } key_rec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rdr_state_e;

endpackage

// File: rtl/paillier_key_reader_fifo.sv
// Two-entry FIFO of key records; the head entry is read straight from its
// register so the consumer sees a registered payload.
module key_rec_fifo
    import paillier_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  key_rec_t                  wr_data,
    input  logic                      rd_en,
    output key_rec_t                  rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [KEY_FIFO_CNT_W-1:0] count
);

    key_rec_t mem [KEY_FIFO_DEPTH];
    logic     wr_ptr;
    logic     rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (rd_en) rd_ptr <= ~rd_ptr;
            count <= count + KEY_FIFO_CNT_W'(wr_en) - KEY_FIFO_CNT_W'(rd_en);
        end
    end

    // Payload storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == KEY_FIFO_CNT_W'(KEY_FIFO_DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/paillier_key_reader.sv
// Drains the u/n/g/lambda key RAMs through a shared read port and streams one
// packed key record per address over a valid/ready interface.
module paillier_key_reader
    import paillier_pkg::*;
#(
    parameter int DATA_WIDTH     = KEY_DATA_WIDTH,
    parameter int RAM_ADDR_WIDTH = KEY_ADDR_WIDTH,
    parameter int FILE_SIZE      = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH:0]   num_keys_i,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH-1:0] out_rd_addr,
    input  logic [DATA_WIDTH-1:0]     u_dout,
    input  logic [DATA_WIDTH-1:0]     n_dout,
    input  logic [DATA_WIDTH-1:0]     g_dout,
    input  logic [DATA_WIDTH-1:0]     lambda_dout,
    output logic                      key_valid,
    input  logic                      key_ready,
    output logic [DATA_WIDTH-1:0]     key_u,
    output logic [DATA_WIDTH-1:0]     key_n,
    output logic [DATA_WIDTH-1:0]     key_g,
    output logic [DATA_WIDTH-1:0]     key_lambda,
    output logic [RAM_ADDR_WIDTH-1:0] key_index,
    output logic                      key_last
);

    localparam logic [RAM_ADDR_WIDTH:0] MAX_KEYS = (RAM_ADDR_WIDTH+1)'(2**RAM_ADDR_WIDTH);
    localparam logic [RAM_ADDR_WIDTH:0] DEF_KEYS = (RAM_ADDR_WIDTH+1)'(FILE_SIZE);
    localparam logic [RAM_ADDR_WIDTH:0] ONE_KEY  = (RAM_ADDR_WIDTH+1)'(1);

    rdr_state_e                state_q, state_d;
    logic [RAM_ADDR_WIDTH:0]   n_q, n_sel, issue_q, acc_q;
    logic [RAM_ADDR_WIDTH-1:0] last_addr_q;
    logic [RAM_ADDR_WIDTH-1:0] idx_p0;
    logic                      vld_p0;
    logic                      issue_en, credit_ok, pop;
    logic                      fifo_full, fifo_empty;
    logic [KEY_FIFO_CNT_W-1:0] fifo_count;
    key_rec_t                  wr_rec, head;

    always_comb begin
        if (num_keys_i == '0)           n_sel = DEF_KEYS;
        else if (num_keys_i > MAX_KEYS) n_sel = MAX_KEYS;
        else                            n_sel = num_keys_i;
    end

    // A read may only be issued if its data is guaranteed a FIFO slot when it
    // lands next cycle; a pop in the same cycle frees one, keeping streaming gapless.
    assign pop       = key_valid && key_ready;
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, vld_p0}) < (3'd2 + {2'b00, pop});
    assign issue_en  = (state_q == RUN) && (issue_q < n_q) && credit_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pop && ((acc_q + ONE_KEY) == n_q)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // p0: address issued to the RAMs this cycle, data arrives on the next
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            issue_q     <= '0;
            acc_q       <= '0;
            last_addr_q <= '0;
            vld_p0      <= 1'b0;
            idx_p0      <= '0;
        end else begin
            state_q <= state_d;
            vld_p0  <= issue_en;
            idx_p0  <= issue_q[RAM_ADDR_WIDTH-1:0];
            if (state_q == IDLE && start) begin
                n_q         <= n_sel;
                issue_q     <= '0;
                acc_q       <= '0;
                last_addr_q <= '0;
            end else if (state_q == FINISH) begin
                last_addr_q <= '0;
            end
            if (issue_en) begin
                issue_q     <= issue_q + ONE_KEY;
                last_addr_q <= issue_q[RAM_ADDR_WIDTH-1:0];
            end
            if (pop) acc_q <= acc_q + ONE_KEY;
        end
    end

    assign out_rd_addr = issue_en ? issue_q[RAM_ADDR_WIDTH-1:0] : last_addr_q;

    always_comb begin
        wr_rec.u      = u_dout;
        wr_rec.n      = n_dout;
        wr_rec.g      = g_dout;
        wr_rec.lambda = lambda_dout;
        wr_rec.index  = idx_p0;
        wr_rec.last   = ({1'b0, idx_p0} == (n_q - ONE_KEY));
    end

    // p1: returned RAM words captured as a record
    key_rec_fifo u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (vld_p0 && !fifo_full),
        .wr_data (wr_rec),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign key_valid  = !fifo_empty;
    assign key_u      = key_valid ? head.u      : '0;
    assign key_n      = key_valid ? head.n      : '0;
    assign key_g      = key_valid ? head.g      : '0;
    assign key_lambda = key_valid ? head.lambda : '0;
    assign key_index  = key_valid ? head.index  : '0;
    assign key_last   = key_valid && head.last;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == FINISH);

endmodule
